ram_responder: RTL and testbench

Word-wide external-memory responder that services the cache-side RAM interface: it accepts single-word read/write requests held by an initiator, waits a programmable latency, answers with a one-cycle `ram_ready` pulse, and then ignores the bus for a turnaround window. It sits below the cache in simulation and FPGA bring-up as the backing store, replacing a real memory controller with the same handshake.

---
 rtl/ram_model_pkg.sv | 22 ++
 rtl/ram_word_array.sv | 32 +++
 rtl/ram_responder.sv | 159 +++++++++++++++
 tb/tb_ram_responder.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram_model_pkg.sv
// Shared types, limits and the parameter-range helper for the ram_responder
// backing-store model.
package ram_model_pkg;

    localparam int MAX_LATENCY = 15;
    localparam int CNT_W       = $clog2(MAX_LATENCY + 1);
    localparam int DATA_W      = 32;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESPOND,
        ST_GUARD
    } resp_state_t;

    function automatic bit param_in_range(input int value, input int lo, input int hi);
        return (value >= lo) && (value <= hi);
    endfunction

endpackage

// File: rtl/ram_word_array.sv
// Single-port word memory with write enable and a registered, read-enabled
// output port.
module ram_word_array
    import ram_model_pkg::*;
#(
    parameter int WORD_ADDR_W = 14
) (
    input  logic                   clk,
    input  logic                   i_we,
    input  logic                   i_re,
    input  logic [WORD_ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0]      i_wdata,
    output logic [DATA_W-1:0]      o_rdata
);

    logic [DATA_W-1:0] r_mem [2**WORD_ADDR_W];
    logic [DATA_W-1:0] r_rdata;

    // NOTE: storage and its read register have no reset, so they map onto block RAM;
    // the responder keeps its own reset-cleared copy of the read data.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/ram_responder.sv
// Cache-side RAM responder: latched single-word requests, programmable latency,
// one-cycle ram_ready pulse, then a turnaround guard window.
module ram_responder
    import ram_model_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 16,
    parameter int READ_LATENCY  = 4,
    parameter int WRITE_LATENCY = 2,
    parameter int TURNAROUND    = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ADDRESS_WIDTH-1:0] ram_address,
    input  logic                     ram_rd,
    input  logic                     ram_wr,
    input  logic [DATA_W-1:0]        ram_data_wr,
    output logic [DATA_W-1:0]        ram_data_rd,
    output logic                     ram_ready,
    output logic                     ram_collision
);

    localparam int   WORD_W     = ADDRESS_WIDTH - 2;
    localparam cnt_t RD_LOAD    = cnt_t'(READ_LATENCY - 1);
    localparam cnt_t WR_LOAD    = cnt_t'(WRITE_LATENCY - 1);
    localparam cnt_t GUARD_LOAD = cnt_t'(TURNAROUND);
    localparam cnt_t CNT_ONE    = cnt_t'(1);

    if (ADDRESS_WIDTH < 3) begin : g_bad_address_width
        $fatal(1, "ram_responder: ADDRESS_WIDTH must be at least 3");
    end
    if (!param_in_range(READ_LATENCY, 1, MAX_LATENCY)) begin : g_bad_read_latency
        $fatal(1, "ram_responder: READ_LATENCY must be in 1..15");
    end
    if (!param_in_range(WRITE_LATENCY, 1, MAX_LATENCY)) begin : g_bad_write_latency
        $fatal(1, "ram_responder: WRITE_LATENCY must be in 1..15");
    end
    if (!param_in_range(TURNAROUND, 2, 7)) begin : g_bad_turnaround
        $fatal(1, "ram_responder: TURNAROUND must be in 2..7");
    end

    resp_state_t       r_state, w_next_state;
    cnt_t              r_cnt, w_next_cnt;
    logic [WORD_W-1:0] r_addr;
    logic              r_is_write;
    logic [DATA_W-1:0] r_wdata;
    logic              r_collision;
    logic [DATA_W-1:0] r_data_hold;

    logic              w_req;
    logic              w_mem_rd_en;
    logic              w_mem_we;
    logic              w_resp_read;
    logic [WORD_W-1:0] w_in_word;
    logic [WORD_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_q;
    logic              w_unused_addr_lsbs;

    assign w_req              = ram_rd | ram_wr;
    assign w_in_word          = ram_address[ADDRESS_WIDTH-1:2];
    assign w_unused_addr_lsbs = ^ram_address[1:0];

    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_mem_rd_en  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    if (ram_wr) begin
                        w_next_state = (WRITE_LATENCY == 1) ? ST_RESPOND : ST_WAIT;
                        w_next_cnt   = WR_LOAD;
                    end else begin
                        w_next_state = (READ_LATENCY == 1) ? ST_RESPOND : ST_WAIT;
                        w_next_cnt   = RD_LOAD;
                        w_mem_rd_en  = (READ_LATENCY == 1);
                    end
                end
            end
            ST_WAIT: begin
                if (!w_req) begin
                    w_next_state = ST_IDLE;
                    w_next_cnt   = '0;
                end else if (r_cnt == CNT_ONE) begin
                    // Launch the registered read one cycle early so data lands in RESPOND.
                    w_next_state = ST_RESPOND;
                    w_next_cnt   = '0;
                    w_mem_rd_en  = !r_is_write;
                end else begin
                    w_next_cnt = r_cnt - CNT_ONE;
                end
            end
            ST_RESPOND: begin
                w_next_state = ST_GUARD;
                w_next_cnt   = GUARD_LOAD;
            end
            ST_GUARD: begin
                if (r_cnt == CNT_ONE) begin
                    w_next_state = ST_IDLE;
                    w_next_cnt   = '0;
                end else begin
                    w_next_cnt = r_cnt - CNT_ONE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_next_cnt   = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_is_write  <= 1'b0;
            r_wdata     <= '0;
            r_collision <= 1'b0;
            r_data_hold <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            if (r_state == ST_IDLE && w_req) begin
                r_addr     <= w_in_word;
                r_is_write <= ram_wr;
                r_wdata    <= ram_data_wr;
            end
            if (r_state == ST_IDLE && ram_rd && ram_wr) begin
                r_collision <= 1'b1;
            end
            if (w_resp_read) begin
                r_data_hold <= w_mem_q;
            end
        end
    end

    // In IDLE the memory looks at the live address so a latency-1 read can launch at once.
    assign w_mem_addr  = (r_state == ST_IDLE) ? w_in_word : r_addr;
    assign w_mem_we    = (r_state == ST_RESPOND) && r_is_write;
    assign w_resp_read = (r_state == ST_RESPOND) && !r_is_write;

    ram_word_array #(
        .WORD_ADDR_W(WORD_W)
    ) u_array (
        .clk    (clk),
        .i_we   (w_mem_we),
        .i_re   (w_mem_rd_en),
        .i_addr (w_mem_addr),
        .i_wdata(r_wdata),
        .o_rdata(w_mem_q)
    );

    assign ram_ready     = (r_state == ST_RESPOND);
    assign ram_data_rd   = w_resp_read ? w_mem_q : r_data_hold;
    assign ram_collision = r_collision;

endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder: latency, burst spacing, abort, collision,
// address aliasing and asynchronous reset behaviour.
module tb_ram_responder;

    localparam int AW = 16;
    localparam int RL = 4;
    localparam int WL = 2;
    localparam int TA = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] ram_address = '0;
    logic          ram_rd = 1'b0;
    logic          ram_wr = 1'b0;
    logic [31:0]   ram_data_wr = '0;
    logic [31:0]   ram_data_rd;
    logic          ram_ready;
    logic          ram_collision;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ready_total = 0;

    ram_responder #(
        .ADDRESS_WIDTH(AW),
        .READ_LATENCY (RL),
        .WRITE_LATENCY(WL),
        .TURNAROUND   (TA)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ram_address  (ram_address),
        .ram_rd       (ram_rd),
        .ram_wr       (ram_wr),
        .ram_data_wr  (ram_data_wr),
        .ram_data_rd  (ram_data_rd),
        .ram_ready    (ram_ready),
        .ram_collision(ram_collision)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) if (ram_ready) ready_total++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic next_cycle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge with the responder in IDLE; returns in IDLE.
    task automatic xact(input logic rd, input logic wr, input logic [AW-1:0] addr,
                        input logic [31:0] data, input int exp_lat, input string tag,
                        output logic [31:0] rdata);
        int n;
        logic found;
        ram_rd = rd;
        ram_wr = wr;
        ram_address = addr;
        ram_data_wr = data;
        n = 0;
        found = 1'b0;
        while (n < 32 && !found) begin
            @(negedge clk);
            n++;
            if (ram_ready) found = 1'b1;
        end
        check({tag, " ready seen"}, 32'(found), 32'd1);
        check({tag, " latency"}, 32'(n - 1), 32'(exp_lat));
        rdata = ram_data_rd;
        next_cycle(1);
        ram_rd = 1'b0;
        ram_wr = 1'b0;
        @(negedge clk);
        check({tag, " pulse width"}, 32'(ram_ready), 32'd0);
        next_cycle(TA);
    endtask

    logic [31:0] rd_val;
    logic [31:0] last_read;
    int          ready_before;
    int          prev_stamp;
    logic        found;

    initial begin
        // Reset state
        next_cycle(3);
        @(negedge clk);
        check("reset ready", 32'(ram_ready), 32'd0);
        check("reset data_rd", ram_data_rd, 32'h0);
        check("reset collision", 32'(ram_collision), 32'd0);
        next_cycle(1);
        rst_n = 1'b1;
        next_cycle(2);

        // Write then read with independent latencies
        xact(1'b0, 1'b1, 16'h0040, 32'hDEADBEEF, WL, "wr 0040", rd_val);
        xact(1'b1, 1'b0, 16'h0040, 32'h0, RL, "rd 0040", rd_val);
        check("rd 0040 data", rd_val, 32'hDEADBEEF);
        last_read = rd_val;

        // Writeback burst, initiator advances address one cycle after each ready
        xact(1'b0, 1'b1, 16'h0110, 32'h0BADF00D, WL, "wr sentinel", rd_val);
        ready_before = ready_total;
        ram_wr = 1'b1;
        ram_address = 16'h0100;
        ram_data_wr = 32'hB0000000;
        prev_stamp = cyc;
        for (int k = 0; k < 4; k++) begin
            found = 1'b0;
            for (int n = 0; n < 32 && !found; n++) begin
                @(negedge clk);
                if (ram_ready) found = 1'b1;
            end
            check($sformatf("burst %0d ready seen", k), 32'(found), 32'd1);
            check($sformatf("burst %0d spacing", k), 32'(cyc - prev_stamp),
                  32'((k == 0) ? WL : WL + TA + 1));
            prev_stamp = cyc;
            next_cycle(2);
            if (k < 3) begin
                ram_address = ram_address + 16'd4;
                ram_data_wr = ram_data_wr + 32'd1;
            end else begin
                ram_wr = 1'b0;
            end
        end
        next_cycle(10);
        check("burst ready count", 32'(ready_total - ready_before), 32'd4);
        for (int k = 0; k < 4; k++) begin
            xact(1'b1, 1'b0, 16'(16'h0100 + 4 * k), 32'h0, RL, "burst readback", rd_val);
            check($sformatf("burst word %0d", k), rd_val, 32'hB0000000 + 32'(k));
        end
        xact(1'b1, 1'b0, 16'h0110, 32'h0, RL, "sentinel readback", rd_val);
        check("sentinel untouched", rd_val, 32'h0BADF00D);
        last_read = rd_val;

        // Abort: drop ram_rd in the 2nd WAIT cycle
        ready_before = ready_total;
        ram_rd = 1'b1;
        ram_address = 16'h0040;
        next_cycle(2);
        ram_rd = 1'b0;
        next_cycle(12);
        check("abort no ready", 32'(ready_total - ready_before), 32'd0);
        check("abort data_rd held", ram_data_rd, last_read);
        xact(1'b0, 1'b1, 16'h0200, 32'hCAFEF00D, WL, "wr 0200", rd_val);
        check("data_rd not changed by write", ram_data_rd, last_read);
        xact(1'b1, 1'b0, 16'h0200, 32'h0, RL, "rd 0200", rd_val);
        check("rd 0200 data", rd_val, 32'hCAFEF00D);

        // Collision: both strobes high is a write and sets the sticky flag
        check("collision before", 32'(ram_collision), 32'd0);
        xact(1'b1, 1'b1, 16'h0010, 32'h12345678, WL, "collision wr", rd_val);
        check("collision set", 32'(ram_collision), 32'd1);
        xact(1'b1, 1'b0, 16'h0010, 32'h0, RL, "rd 0010", rd_val);
        check("rd 0010 data", rd_val, 32'h12345678);
        check("collision sticky", 32'(ram_collision), 32'd1);

        // Address low bits ignored, top word, no alias with word 0
        xact(1'b0, 1'b1, 16'hFFFF, 32'h13579BDF, WL, "wr FFFF", rd_val);
        xact(1'b0, 1'b1, 16'h0000, 32'h2468ACE0, WL, "wr 0000", rd_val);
        xact(1'b1, 1'b0, 16'hFFFC, 32'h0, RL, "rd FFFC", rd_val);
        check("rd FFFC data", rd_val, 32'h13579BDF);
        xact(1'b1, 1'b0, 16'h0002, 32'h0, RL, "rd 0002", rd_val);
        check("rd 0002 data", rd_val, 32'h2468ACE0);

        // Reset during WAIT of a write drops it
        xact(1'b0, 1'b1, 16'h0080, 32'hAAAAAAAA, WL, "wr 0080", rd_val);
        ram_wr = 1'b1;
        ram_address = 16'h0080;
        ram_data_wr = 32'h55555555;
        next_cycle(1);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset in WAIT ready", 32'(ram_ready), 32'd0);
        check("reset clears collision", 32'(ram_collision), 32'd0);
        check("reset clears data_rd", ram_data_rd, 32'h0);
        next_cycle(2);
        ram_wr = 1'b0;
        rst_n = 1'b1;
        next_cycle(2);

        // Reset during RESPOND of a write: ready falls at once, no commit
        ram_wr = 1'b1;
        ram_address = 16'h0080;
        ram_data_wr = 32'h55555555;
        next_cycle(WL);
        @(negedge clk);
        check("RESPOND before reset", 32'(ram_ready), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("reset in RESPOND ready", 32'(ram_ready), 32'd0);
        next_cycle(2);
        ram_wr = 1'b0;
        rst_n = 1'b1;
        next_cycle(2);
        xact(1'b1, 1'b0, 16'h0080, 32'h0, RL, "rd 0080", rd_val);
        check("rd 0080 kept", rd_val, 32'hAAAAAAAA);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
